logo_motion_ctrl: RTL and testbench

LOGO_MOTION_CTRL -- requirements
Module: logo_motion_ctrl

---
 rtl/logo_motion_ctrl_pkg.sv | 29 ++
 rtl/logo_motion_ctrl_if.sv | 30 +++
 rtl/logo_motion_ctrl_axis_bouncer.sv | 52 +++++
 rtl/logo_motion_ctrl.sv | 126 ++++++++++++
 tb/tb_logo_motion_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/logo_motion_ctrl_pkg.sv
// Shared VGA definitions for the bouncing-logo controller: visible-area timing,
// reset position, arithmetic widths, FSM state and direction encodings.
package logo_motion_ctrl_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_V_ACTIVE = 480;

  localparam int unsigned POS_W   = 10;  // pixel coordinate width
  localparam int unsigned EXT_W   = 11;  // position intermediates, one bit of headroom
  localparam int unsigned SPD_W   = 3;
  localparam int unsigned ROM_W   = 7;
  localparam int unsigned COLOR_W = 3;

  localparam int unsigned X_RST = 256;
  localparam int unsigned Y_RST = 128;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_UPD_X = 2'd1,
    ST_UPD_Y = 2'd2
  } state_t;

  // INC = right / down, DEC = left / up
  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_t;

endpackage

// File: rtl/logo_motion_ctrl_if.sv
// Video-side bundle of the logo controller.
//   master: sync generator / consumer side (drives timing, speed, pause)
//   slave : logo_motion_ctrl (drives position, window hit, ROM address, palette)
interface logo_motion_ctrl_if;
  import logo_motion_ctrl_pkg::*;

  logic [POS_W-1:0]   hpos;
  logic [POS_W-1:0]   vpos;
  logic               display_on;
  logic [SPD_W-1:0]   speed;
  logic               pause;
  logic [POS_W-1:0]   logo_x;
  logic [POS_W-1:0]   logo_y;
  logic               logo_hit;
  logic [ROM_W-1:0]   rom_x;
  logic [ROM_W-1:0]   rom_y;
  logic [COLOR_W-1:0] color_offset;
  logic               bounce;

  modport master (
    output hpos, vpos, display_on, speed, pause,
    input  logo_x, logo_y, logo_hit, rom_x, rom_y, color_offset, bounce
  );

  modport slave (
    input  hpos, vpos, display_on, speed, pause,
    output logo_x, logo_y, logo_hit, rom_x, rom_y, color_offset, bounce
  );

endinterface

// File: rtl/logo_motion_ctrl_axis_bouncer.sv
// One-axis bounce step: given the current position, direction and speed,
// produce the next position/direction and flag an edge hit. Pure combinational.
//   pos/dir/spd   : current axis state and step size
//   pos_next_c    : clamped next position
//   dir_next_c    : direction after the step (flips on an edge hit)
//   hit_c         : edge reached this step
module axis_bouncer
  import logo_motion_ctrl_pkg::*;
#(
  parameter int unsigned MAX = 512
) (
  input  logic [POS_W-1:0] pos,
  input  dir_t             dir,
  input  logic [SPD_W-1:0] spd,
  output logic [POS_W-1:0] pos_next_c,
  output dir_t             dir_next_c,
  output logic             hit_c
);

  logic [EXT_W-1:0] pos_ext;
  logic [EXT_W-1:0] spd_ext;
  logic [EXT_W-1:0] sum;

  assign pos_ext = EXT_W'(pos);
  assign spd_ext = EXT_W'(spd);
  assign sum     = pos_ext + spd_ext;

  // Clamp to the edge and reverse when the step would reach or pass it
  always_comb begin
    pos_next_c = pos;
    dir_next_c = dir;
    hit_c      = 1'b0;
    if (dir == DIR_INC) begin
      if (sum >= EXT_W'(MAX)) begin
        pos_next_c = POS_W'(MAX);
        dir_next_c = DIR_DEC;
        hit_c      = 1'b1;
      end else begin
        pos_next_c = POS_W'(sum);
      end
    end else begin
      if (pos_ext <= spd_ext) begin
        pos_next_c = '0;
        dir_next_c = DIR_INC;
        hit_c      = 1'b1;
      end else begin
        pos_next_c = POS_W'(pos_ext - spd_ext);
      end
    end
  end

endmodule

// File: rtl/logo_motion_ctrl.sv
// Bouncing-logo motion controller. Once per frame, at the start of vertical
// blanking, steps the logo by `speed` pixels on X then Y, bouncing off the
// visible-area edges and rotating the palette on each bounce.
//   clk, rst_n : pixel clock, async active-low reset
//   bus        : slave side of logo_motion_ctrl_if (timing/speed/pause in;
//                position, window hit, ROM address, palette index, bounce out)
module logo_motion_ctrl
  import logo_motion_ctrl_pkg::*;
#(
  parameter int unsigned LOGO_W   = 128,
  parameter int unsigned LOGO_H   = 128,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE
) (
  input  logic               clk,
  input  logic               rst_n,
  logo_motion_ctrl_if.slave  bus
);

  localparam int unsigned XMAX = H_ACTIVE - LOGO_W;
  localparam int unsigned YMAX = V_ACTIVE - LOGO_H;

  state_t             state_q, state_d;
  logic [SPD_W-1:0]   spd_q;
  logic [POS_W-1:0]   logo_x_q, logo_y_q;
  dir_t               dir_x_q, dir_y_q;
  logic               bx_q;
  logic [COLOR_W-1:0] color_q;
  logic               bounce_q;

  logic               frame_start_c;
  logic               cap_en, x_en, y_en;
  logic [POS_W-1:0]   x_next_c, y_next_c;
  dir_t               dir_x_next_c, dir_y_next_c;
  logic               hit_x_c, hit_y_c;

  // First blanking line, first pixel: occurs once per frame
  assign frame_start_c = (bus.hpos == '0) && (bus.vpos == POS_W'(V_ACTIVE));

  axis_bouncer #(.MAX(XMAX)) u_axis_x (
    .pos(logo_x_q), .dir(dir_x_q), .spd(spd_q),
    .pos_next_c(x_next_c), .dir_next_c(dir_x_next_c), .hit_c(hit_x_c)
  );

  axis_bouncer #(.MAX(YMAX)) u_axis_y (
    .pos(logo_y_q), .dir(dir_y_q), .spd(spd_q),
    .pos_next_c(y_next_c), .dir_next_c(dir_y_next_c), .hit_c(hit_y_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_WAIT;
    else        state_q <= state_d;
  end

  // Next state and per-state update strobes
  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    x_en    = 1'b0;
    y_en    = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (frame_start_c && !bus.pause) begin
          state_d = ST_UPD_X;
          cap_en  = 1'b1;
        end
      end
      ST_UPD_X: begin
        state_d = ST_UPD_Y;
        x_en    = 1'b1;
      end
      ST_UPD_Y: begin
        state_d = ST_WAIT;
        y_en    = 1'b1;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Motion datapath; the Y hit is folded in directly so a corner gives one pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spd_q    <= '0;
      logo_x_q <= POS_W'(X_RST);
      logo_y_q <= POS_W'(Y_RST);
      dir_x_q  <= DIR_INC;
      dir_y_q  <= DIR_INC;
      bx_q     <= 1'b0;
      color_q  <= '0;
      bounce_q <= 1'b0;
    end else begin
      bounce_q <= 1'b0;
      if (cap_en) spd_q <= bus.speed;
      if (x_en) begin
        logo_x_q <= x_next_c;
        dir_x_q  <= dir_x_next_c;
        bx_q     <= hit_x_c;
      end
      if (y_en) begin
        logo_y_q <= y_next_c;
        dir_y_q  <= dir_y_next_c;
        bx_q     <= 1'b0;
        if (bx_q || hit_y_c) begin
          bounce_q <= 1'b1;
          color_q  <= color_q + COLOR_W'(1);
        end
      end
    end
  end

  // Window decode against registers that only move during blanking
  assign bus.logo_hit = bus.display_on
                      && (bus.hpos >= logo_x_q)
                      && (EXT_W'(bus.hpos) < EXT_W'(logo_x_q) + EXT_W'(LOGO_W))
                      && (bus.vpos >= logo_y_q)
                      && (EXT_W'(bus.vpos) < EXT_W'(logo_y_q) + EXT_W'(LOGO_H));
  assign bus.rom_x = ROM_W'(bus.hpos - logo_x_q);
  assign bus.rom_y = ROM_W'(bus.vpos - logo_y_q);

  assign bus.logo_x       = logo_x_q;
  assign bus.logo_y       = logo_y_q;
  assign bus.color_offset = color_q;
  assign bus.bounce       = bounce_q;

endmodule

// File: tb/tb_logo_motion_ctrl.sv
// Self-checking bench for logo_motion_ctrl: directed scenarios plus randomized
// frames, compared against a per-frame behavioural model of the bounce rules.
module tb_logo_motion_ctrl;

  localparam int V_ACT = 480;
  localparam int XMAXR = 512;
  localparam int YMAXR = 352;

  logic clk;
  logic rst_n;

  logo_motion_ctrl_if bus ();

  logo_motion_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: position, direction (1 = left/up), palette
  int mx, my, mcol, exp_pulses;
  bit mdx, mdy;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    mx = 256; my = 128; mdx = 1'b0; mdy = 1'b0; mcol = 0; exp_pulses = 0;
  endtask

  task automatic axis_ref(input int pos, input bit dec, input int spd, input int lim,
                          output int np, output bit nd, output bit hit);
    np = pos; nd = dec; hit = 1'b0;
    if (!dec) begin
      if (pos + spd >= lim) begin np = lim; nd = 1'b1; hit = 1'b1; end
      else np = pos + spd;
    end else begin
      if (pos <= spd) begin np = 0; nd = 1'b0; hit = 1'b1; end
      else np = pos - spd;
    end
  endtask

  task automatic model_frame(input int spd, input bit p);
    int nx, ny;
    bit ndx, ndy, hx, hy;
    exp_pulses = 0;
    if (!p) begin
      axis_ref(mx, mdx, spd, XMAXR, nx, ndx, hx);
      axis_ref(my, mdy, spd, YMAXR, ny, ndy, hy);
      mx = nx; my = ny; mdx = ndx; mdy = ndy;
      if (hx || hy) begin
        mcol = (mcol + 1) % 8;
        exp_pulses = 1;
      end
    end
  endtask

  // One frame: frame_start cycle with speed s0, then speed changed to s1 mid-update
  task automatic do_frame(input int s0, input int s1, input bit p, output int pulses);
    bus.speed = 3'(s0); bus.pause = p; bus.display_on = 1'b0;
    bus.hpos = 10'd0; bus.vpos = 10'(V_ACT);
    @(negedge clk);
    bus.hpos = 10'd1; bus.speed = 3'(s1);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.bounce) pulses++;
    end
    model_frame(s0, p);
  endtask

  task automatic frame_chk(input string tag, input int s0, input int s1, input bit p);
    int pulses;
    do_frame(s0, s1, p, pulses);
    chk({tag, "_x"}, int'(bus.logo_x), mx);
    chk({tag, "_y"}, int'(bus.logo_y), my);
    chk({tag, "_col"}, int'(bus.color_offset), mcol);
    chk({tag, "_bounce"}, pulses, exp_pulses);
  endtask

  task automatic probe(input string tag, input int hp, input int vp, input bit dsp);
    int eh;
    bus.hpos = 10'(hp); bus.vpos = 10'(vp); bus.display_on = dsp;
    #1;
    eh = (dsp && hp >= mx && hp < mx + 128 && vp >= my && vp < my + 128) ? 1 : 0;
    chk({tag, "_hit"}, int'(bus.logo_hit), eh);
    chk({tag, "_romx"}, int'(bus.rom_x), (hp - mx) & 127);
    chk({tag, "_romy"}, int'(bus.rom_y), (vp - my) & 127);
  endtask

  task automatic apply_reset();
    bus.hpos = 10'd1; bus.vpos = 10'd0; bus.display_on = 1'b0;
    bus.speed = 3'd0; bus.pause = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    int pulses, g, col0, rem, s, l, xd, yd, hp, vp;

    apply_reset();
    chk("rst_x", int'(bus.logo_x), 256);
    chk("rst_y", int'(bus.logo_y), 128);
    chk("rst_col", int'(bus.color_offset), 0);
    chk("rst_bounce", int'(bus.bounce), 0);

    // Scenario 1: one frame at speed 2
    frame_chk("s1", 2, 2, 1'b0);
    chk("s1_x_const", int'(bus.logo_x), 258);
    chk("s1_y_const", int'(bus.logo_y), 130);

    // Scenario 2: run right to 510, then step 4 into the right edge
    g = 0;
    while (mx != 510 && g < 300) begin
      do_frame(2, 2, 1'b0, pulses);
      g++;
    end
    chk("s2_reach", int'(bus.logo_x), 510);
    col0 = mcol;
    frame_chk("s2_hit", 4, 4, 1'b0);
    chk("s2_x_const", int'(bus.logo_x), 512);
    chk("s2_col_inc", int'(bus.color_offset), (col0 + 1) % 8);
    frame_chk("s2_left", 1, 1, 1'b0);
    chk("s2_left_const", int'(bus.logo_x), 511);

    // Scenario 6: reset asserted while in UPD_Y
    bus.speed = 3'd3; bus.pause = 1'b0; bus.hpos = 10'd0; bus.vpos = 10'(V_ACT);
    @(negedge clk);
    bus.hpos = 10'd1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("s6_x", int'(bus.logo_x), 256);
    chk("s6_y", int'(bus.logo_y), 128);
    chk("s6_col", int'(bus.color_offset), 0);
    chk("s6_bounce", int'(bus.bounce), 0);
    model_reset();
    probe("s6_win", 256, 128, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.hpos = 10'd1; bus.vpos = 10'd0;
    repeat (3) @(negedge clk);
    chk("s6_idle_x", int'(bus.logo_x), 256);
    frame_chk("s6_next", 1, 1, 1'b0);
    chk("s6_next_const", int'(bus.logo_x), 257);

    // Scenario 4: paused frames change nothing
    for (int i = 0; i < 3; i++) frame_chk("s4_pause", 5, 5, 1'b1);
    chk("s4_x_const", int'(bus.logo_x), 257);

    // Scenario 5: speed change during UPD_X applies next frame
    g = mx;
    frame_chk("s5_cur", 2, 7, 1'b0);
    chk("s5_cur_delta", int'(bus.logo_x) - g, 2);
    g = mx;
    frame_chk("s5_next", 7, 7, 1'b0);
    chk("s5_next_delta", int'(bus.logo_x) - g, 7);

    // Randomized frames with window probes
    for (int i = 0; i < 150; i++) begin
      frame_chk("rnd", int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                ($urandom_range(0, 4) == 0));
      for (int k = 0; k < 2; k++) begin
        hp = mx + int'($urandom_range(0, 140)) - 6;
        vp = my + int'($urandom_range(0, 140)) - 6;
        if (hp < 0) hp = 0;
        if (vp < 0) vp = 0;
        if (hp == 0 && vp == V_ACT) vp = 0;
        probe("rnd_win", hp, vp, ($urandom_range(0, 3) != 0));
      end
    end

    // Scenario 3: steer to x=1 moving left with y=351 moving down, then corner hit.
    // X loses 32 steps in total by overshooting edges while Y stays exact.
    apply_reset();
    rem = 32;
    g = 0;
    while (!(mx == 1 && mdx && my == 351 && !mdy) && g < 9000) begin
      s = 1;
      xd = mdx ? mx : XMAXR - mx;
      yd = mdy ? my : YMAXR - my;
      if (rem > 0 && xd == 1 && yd > 7) begin
        l = (rem > 6) ? 6 : rem;
        s = 1 + l;
        rem -= l;
      end
      do_frame(s, s, 1'b0, pulses);
      g++;
    end
    chk("s3_reach", (g < 9000) ? 1 : 0, 1);
    chk("s3_pre_x", int'(bus.logo_x), 1);
    chk("s3_pre_y", int'(bus.logo_y), 351);
    col0 = mcol;
    frame_chk("s3_corner", 3, 3, 1'b0);
    chk("s3_x_const", int'(bus.logo_x), 0);
    chk("s3_y_const", int'(bus.logo_y), 352);
    chk("s3_col_inc", int'(bus.color_offset), (col0 + 1) % 8);
    frame_chk("s3_after", 1, 1, 1'b0);
    chk("s3_after_x", int'(bus.logo_x), 1);
    chk("s3_after_y", int'(bus.logo_y), 351);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
